// File: rtl/qci_cfg_pkg.sv
// Shared definitions for the Qci reserved-bandwidth table writer:
// config-frame opcodes, field positions, FSM states and counter width.
package qci_cfg_pkg;

  // Header opcodes
  localparam logic [7:0] QCI_OP_WRITE = 8'h01;
  localparam logic [7:0] QCI_OP_CLEAR = 8'h02;

  // Header beat fields
  localparam int HDR_OP_LSB  = 56;
  localparam int HDR_OP_W    = 8;
  localparam int HDR_CNT_LSB = 48;
  localparam int HDR_CNT_W   = 8;

  // Entry beat fields
  localparam int ENT_MID_LSB = 32;
  localparam int ENT_MID_W   = 12;
  localparam int ENT_BW_LSB  = 0;
  localparam int ENT_BW_W    = 32;

  // Width of the status counters
  localparam int SAT_W = 16;

  typedef enum logic [2:0] {
    INIT_CLR,
    IDLE,
    WRITE,
    CLR,
    DRAIN
  } qci_state_t;

endpackage

// File: rtl/qci_sat_counter.sv
// Saturating up-counter; adds 0, 1 or 2 per cycle and sticks at all-ones.
module qci_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH:0] sum;

  // One extra bit catches any overflow, since max + 2 never exceeds 2**(WIDTH+1)-1
  always_comb begin
    sum = {1'b0, count} + {{(WIDTH-1){1'b0}}, inc};
  end

  // Count register; saturates instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (sum[WIDTH]) begin
      count <= '1;
    end else begin
      count <= sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/qci_reserved_bandwidth_table_writer.sv
// Management-side writer for port A of the Qci reserved-bandwidth table.
// Turns 64-bit AXI-Stream config frames into table writes, sweeps the
// table to DEFAULT_BW after reset and on CLEAR, and keeps status counters.
module qci_reserved_bandwidth_table_writer
  import qci_cfg_pkg::*;
#(
  parameter int                ADDR_W     = 7,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] DEFAULT_BW = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       s_axis_cfg_tdata,
  input  logic [7:0]        s_axis_cfg_tkeep,
  input  logic              s_axis_cfg_tlast,
  input  logic              s_axis_cfg_tvalid,
  output logic              s_axis_cfg_tready,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  output logic              busy,
  output logic [SAT_W-1:0]  entries_written,
  output logic [SAT_W-1:0]  err_count
);

  qci_state_t state, state_nxt;

  logic [ADDR_W-1:0]    sweep_addr;
  logic [HDR_CNT_W-1:0] rem;
  logic                 hdr_last;

  logic                 accept;
  logic [HDR_OP_W-1:0]  op;
  logic [HDR_CNT_W-1:0] cnt;
  logic [ENT_MID_W-1:0] meter_id;
  logic [DATA_W-1:0]    bw;
  logic                 in_range;
  logic                 last_entry;
  logic                 sweep_last;

  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic [1:0]           ent_inc;
  logic [1:0]           err_inc;

  // tkeep is ignored and entry bits [47:44] carry nothing
  logic unused_ok;
  assign unused_ok = ^{s_axis_cfg_tkeep, s_axis_cfg_tdata[47:44]};

  assign accept     = s_axis_cfg_tvalid && s_axis_cfg_tready;
  assign op         = s_axis_cfg_tdata[HDR_OP_LSB +: HDR_OP_W];
  assign cnt        = s_axis_cfg_tdata[HDR_CNT_LSB +: HDR_CNT_W];
  assign meter_id   = s_axis_cfg_tdata[ENT_MID_LSB +: ENT_MID_W];
  assign bw         = s_axis_cfg_tdata[ENT_BW_LSB +: DATA_W];
  // Shift rather than slice so ADDR_W = 12 (no upper bits) stays legal
  assign in_range   = (meter_id >> ADDR_W) == '0;
  assign last_entry = (rem == 8'd1);
  assign sweep_last = &sweep_addr;

  // State register
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT_CLR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  // NOTE: the default before the case keeps this purely combinational;
  // any path leaving state_nxt unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT_CLR: if (sweep_last) state_nxt = IDLE;
      CLR:      if (sweep_last) state_nxt = hdr_last ? IDLE : DRAIN;
      IDLE: begin
        if (accept) begin
          if (op == QCI_OP_CLEAR) begin
            state_nxt = CLR;
          end else if (op == QCI_OP_WRITE) begin
            if (s_axis_cfg_tlast)  state_nxt = IDLE;
            else if (cnt == '0)    state_nxt = DRAIN;
            else                   state_nxt = WRITE;
          end else begin
            state_nxt = s_axis_cfg_tlast ? IDLE : DRAIN;
          end
        end
      end
      WRITE: begin
        if (accept) begin
          if (s_axis_cfg_tlast) state_nxt = IDLE;
          else if (last_entry)  state_nxt = DRAIN;
        end
      end
      DRAIN:   if (accept && s_axis_cfg_tlast) state_nxt = IDLE;
      default: state_nxt = INIT_CLR;
    endcase
  end

  // Handshake, write request and counter increments for the current cycle
  always_comb begin
    s_axis_cfg_tready = 1'b0;
    busy              = 1'b0;
    wr_en             = 1'b0;
    wr_addr           = '0;
    wr_data           = '0;
    ent_inc           = 2'd0;
    err_inc           = 2'd0;
    case (state)
      INIT_CLR, CLR: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = sweep_addr;
        wr_data = DEFAULT_BW;
      end
      IDLE: begin
        s_axis_cfg_tready = 1'b1;
        if (accept) begin
          if (op == QCI_OP_WRITE) begin
            // WRITE header that promises entries but ends, or promises none but continues
            if (s_axis_cfg_tlast == (cnt != '0)) err_inc = 2'd1;
          end else if (op != QCI_OP_CLEAR) begin
            err_inc = 2'd1;
          end
        end
      end
      WRITE: begin
        s_axis_cfg_tready = 1'b1;
        if (accept) begin
          if (in_range) begin
            wr_en   = 1'b1;
            wr_addr = meter_id[ADDR_W-1:0];
            wr_data = bw;
            ent_inc = 2'd1;
          end else begin
            err_inc = err_inc + 2'd1;
          end
          // Frame length disagrees with the header count (early or missing tlast)
          if (s_axis_cfg_tlast != last_entry) err_inc = err_inc + 2'd1;
        end
      end
      DRAIN:   s_axis_cfg_tready = 1'b1;
      default: ;
    endcase
  end

  // Sweep address, remaining-entry count and latched header tlast
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_addr <= '0;
      rem        <= '0;
      hdr_last   <= 1'b0;
    end else begin
      sweep_addr <= busy ? sweep_addr + 1'b1 : '0;
      if (state == IDLE && accept) begin
        rem      <= cnt;
        hdr_last <= s_axis_cfg_tlast;
      end else if (state == WRITE && accept) begin
        rem <= rem - 1'b1;
      end
    end
  end

  // Registered port A: every write lands one cycle after its request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_ena   <= 1'b0;
      ram_wea   <= 1'b0;
      ram_addra <= '0;
      ram_dina  <= '0;
    end else begin
      ram_ena   <= wr_en;
      ram_wea   <= wr_en;
      ram_addra <= wr_addr;
      ram_dina  <= wr_data;
    end
  end

  qci_sat_counter #(.WIDTH(SAT_W)) u_entries_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ent_inc),
    .count (entries_written)
  );

  qci_sat_counter #(.WIDTH(SAT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (err_count)
  );

endmodule

// File: tb/tb_qci_reserved_bandwidth_table_writer.sv
// Directed bench for qci_reserved_bandwidth_table_writer (default parameters).
// Expected port-A writes go into a scoreboard queue when stimulus is driven;
// a negedge monitor pops and compares them, including the exact cycle.
module tb_qci_reserved_bandwidth_table_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_axis_cfg_tdata;
  logic [7:0]  s_axis_cfg_tkeep;
  logic        s_axis_cfg_tlast;
  logic        s_axis_cfg_tvalid;
  logic        s_axis_cfg_tready;
  logic        ram_ena;
  logic        ram_wea;
  logic [6:0]  ram_addra;
  logic [31:0] ram_dina;
  logic        busy;
  logic [15:0] entries_written;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  qci_reserved_bandwidth_table_writer dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_cfg_tdata  (s_axis_cfg_tdata),
    .s_axis_cfg_tkeep  (s_axis_cfg_tkeep),
    .s_axis_cfg_tlast  (s_axis_cfg_tlast),
    .s_axis_cfg_tvalid (s_axis_cfg_tvalid),
    .s_axis_cfg_tready (s_axis_cfg_tready),
    .ram_ena           (ram_ena),
    .ram_wea           (ram_wea),
    .ram_addra         (ram_addra),
    .ram_dina          (ram_dina),
    .busy              (busy),
    .entries_written   (entries_written),
    .err_count         (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every port-A write must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (ram_ena === 1'b1) begin
      check("ram_wea", 64'(ram_wea), 64'd1);
      check("wr_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(ram_addra), 64'(e.addr));
        check("wr_data", 64'(ram_dina), 64'(e.data));
        check("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] hdr(input logic [7:0] op, input logic [7:0] n);
    return {op, n, 48'h0};
  endfunction

  function automatic logic [63:0] ent(input logic [11:0] mid, input logic [31:0] bw);
    return {20'h0, mid, bw};
  endfunction

  task automatic idle();
    s_axis_cfg_tvalid = 1'b0;
    s_axis_cfg_tlast  = 1'b0;
    s_axis_cfg_tdata  = '0;
  endtask

  // Drive one beat until accepted; queue its write if one is expected
  task automatic send_beat(input logic [63:0] d, input logic last, input logic exp_wr,
                           input logic [6:0] a, input logic [31:0] bw);
    int n = 0;
    s_axis_cfg_tdata  = d;
    s_axis_cfg_tlast  = last;
    s_axis_cfg_tvalid = 1'b1;
    while (s_axis_cfg_tready !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    check("tready_wait", 64'(s_axis_cfg_tready), 64'd1);
    if (exp_wr) exp_q.push_back('{addr: a, data: bw, cyc: cyc + 1});
    step();
  endtask

  task automatic check_counts(input string tag, input int ew, input int ec);
    check({tag, "_entries"}, 64'(entries_written), 64'(ew));
    check({tag, "_errs"}, 64'(err_count), 64'(ec));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tready"}, 64'(s_axis_cfg_tready), 64'd0);
    check({tag, "_ena"}, 64'(ram_ena), 64'd0);
    check({tag, "_wea"}, 64'(ram_wea), 64'd0);
    check({tag, "_addra"}, 64'(ram_addra), 64'd0);
    check({tag, "_dina"}, 64'(ram_dina), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check_counts(tag, 0, 0);
  endtask

  // Full 128-address clear starting with the write seen on the next edge
  task automatic sweep_check(input string tag);
    int base = cyc;
    for (int i = 0; i < 128; i++) exp_q.push_back('{addr: 7'(i), data: 32'h0, cyc: base + 1 + i});
    for (int i = 0; i < 128; i++) begin
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_tready"}, 64'(s_axis_cfg_tready), 64'd0);
      step();
    end
    check({tag, "_done_busy"}, 64'(busy), 64'd0);
    check({tag, "_done_tready"}, 64'(s_axis_cfg_tready), 64'd1);
  endtask

  initial begin
    rst              = 1'b1;
    s_axis_cfg_tkeep = 8'hFF;
    idle();
    step();
    step();
    check_reset_vals("rst");

    // Power-on clear sweep
    rst = 1'b0;
    sweep_check("init_sweep");
    check_counts("init", 0, 0);

    // Two good entries back to back, tlast on the second
    send_beat(hdr(8'h01, 8'd2), 1'b0, 1'b0, 7'd0, 32'h0);
    send_beat(ent(12'd5, 32'd1000), 1'b0, 1'b1, 7'd5, 32'd1000);
    send_beat(ent(12'd127, 32'hFFFF_FFFF), 1'b1, 1'b1, 7'd127, 32'hFFFF_FFFF);
    idle();
    check_counts("wr2", 2, 0);

    // Out-of-range meter id: no write, one error
    send_beat(hdr(8'h01, 8'd1), 1'b0, 1'b0, 7'd0, 32'h0);
    send_beat(ent(12'd200, 32'h1234), 1'b1, 1'b0, 7'd0, 32'h0);
    idle();
    check_counts("oor", 2, 1);

    // N=3 but tlast on the 2nd entry, then a normal frame
    send_beat(hdr(8'h01, 8'd3), 1'b0, 1'b0, 7'd0, 32'h0);
    send_beat(ent(12'd10, 32'h11), 1'b0, 1'b1, 7'd10, 32'h11);
    send_beat(ent(12'd20, 32'h22), 1'b1, 1'b1, 7'd20, 32'h22);
    send_beat(hdr(8'h01, 8'd1), 1'b0, 1'b0, 7'd0, 32'h0);
    send_beat(ent(12'd30, 32'h33), 1'b1, 1'b1, 7'd30, 32'h33);
    idle();
    check_counts("early_last", 5, 2);

    // CLEAR without tlast; a trailing beat waits through the sweep, then drained
    send_beat(hdr(8'h02, 8'd0), 1'b0, 1'b0, 7'd0, 32'h0);
    s_axis_cfg_tdata  = ent(12'd1, 32'h77);
    s_axis_cfg_tlast  = 1'b0;
    s_axis_cfg_tvalid = 1'b1;
    sweep_check("clr_sweep");
    send_beat(ent(12'd1, 32'h77), 1'b0, 1'b0, 7'd0, 32'h0);
    send_beat(ent(12'd2, 32'h88), 1'b1, 1'b0, 7'd0, 32'h0);
    idle();
    check_counts("clr_drain", 5, 2);

    // Out-of-range and premature tlast on the same beat: +2
    send_beat(hdr(8'h01, 8'd3), 1'b0, 1'b0, 7'd0, 32'h0);
    send_beat(ent(12'd300, 32'h99), 1'b1, 1'b0, 7'd0, 32'h0);
    idle();
    check_counts("double_err", 5, 4);

    // Unknown opcode with tlast; WRITE N=0 with tlast is silent
    send_beat(hdr(8'h07, 8'd4), 1'b1, 1'b0, 7'd0, 32'h0);
    send_beat(hdr(8'h01, 8'd0), 1'b1, 1'b0, 7'd0, 32'h0);
    idle();
    check_counts("bad_op", 5, 5);

    // WRITE N=0 without tlast: error, entry-like beat drained
    send_beat(hdr(8'h01, 8'd0), 1'b0, 1'b0, 7'd0, 32'h0);
    send_beat(ent(12'd60, 32'h60), 1'b1, 1'b0, 7'd0, 32'h0);
    idle();
    check_counts("n0_drain", 5, 6);

    // tvalid gap mid-frame: no writes while idle
    send_beat(hdr(8'h01, 8'd2), 1'b0, 1'b0, 7'd0, 32'h0);
    send_beat(ent(12'd40, 32'h44), 1'b0, 1'b1, 7'd40, 32'h44);
    idle();
    repeat (3) step();
    send_beat(ent(12'd41, 32'h45), 1'b1, 1'b1, 7'd41, 32'h45);
    idle();
    check_counts("gap", 7, 6);

    // Count reached without tlast: error, rest drained
    send_beat(hdr(8'h01, 8'd1), 1'b0, 1'b0, 7'd0, 32'h0);
    send_beat(ent(12'd42, 32'h46), 1'b0, 1'b1, 7'd42, 32'h46);
    send_beat(ent(12'd43, 32'h47), 1'b1, 1'b0, 7'd0, 32'h0);
    idle();
    check_counts("no_last", 8, 7);

    // Reset during the 3rd entry of an N=5 frame
    send_beat(hdr(8'h01, 8'd5), 1'b0, 1'b0, 7'd0, 32'h0);
    send_beat(ent(12'd50, 32'h50), 1'b0, 1'b1, 7'd50, 32'h50);
    send_beat(ent(12'd51, 32'h51), 1'b0, 1'b1, 7'd51, 32'h51);
    check_counts("pre_rst", 10, 7);
    s_axis_cfg_tdata  = ent(12'd52, 32'h52);
    s_axis_cfg_tvalid = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    idle();
    step();
    step();
    rst = 1'b0;
    sweep_check("rst_sweep");

    // Fresh frame after the re-sweep
    send_beat(hdr(8'h01, 8'd1), 1'b0, 1'b0, 7'd0, 32'h0);
    send_beat(ent(12'd3, 32'hABCD), 1'b1, 1'b1, 7'd3, 32'hABCD);
    idle();
    check_counts("post_rst", 1, 0);

    step();
    step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
